// File: rtl/prbs_checker.sv
// PRBS stream checker: self-synchronises to a serial Galois-LFSR pattern and
// reports lock, per-bit error pulses and a saturating error count.
// While searching, the history is loaded from the received bits. Once locked,
// it is loaded from its own predictions, so a single line error cannot
// corrupt the reference. Lock is dropped when too many errors land in one
// monitoring window.
module prbs_checker #(
   parameter int unsigned      WIDTH      = 16,
   parameter logic [WIDTH-1:0] POLY       = 16'hB400,
   parameter int unsigned      LOCK_CNT   = 32,
   parameter int unsigned      WINDOW     = 64,
   parameter int unsigned      UNLOCK_ERR = 8,
   parameter int unsigned      CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             din,
   input  logic             din_vld,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
   localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int unsigned BAD_W   = $clog2(UNLOCK_ERR + 1);

   typedef enum logic [0:0] {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic [WIN_W-1:0]   win_q, win_d;
   logic [BAD_W-1:0]   bad_q, bad_d;
   logic               locked_q, locked_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

   logic               pred_s;
   logic               miss_s;
   logic [BAD_W-1:0]   bad_inc_s;
   logic [CNT_W-1:0]   cnt_base_s;

   // Next bit predicted by the recurrence from the current history.
   assign pred_s = ^(hist_q & POLY);

   // Next-state logic: search/lock tracking, window monitor and error counter.
   always_comb begin
      state_d    = state_q;
      hist_d     = hist_q;
      fill_d     = fill_q;
      match_d    = match_q;
      win_d      = win_q;
      bad_d      = bad_q;
      miss_s     = 1'b0;
      bad_inc_s  = bad_q;
      cnt_base_s = err_cnt_q;
      err_d      = 1'b0;
      err_cnt_d  = err_cnt_q;
      locked_d   = 1'b0;

      if (din_vld) begin
         case (state_q)
            ST_SEARCH: begin
               hist_d = {hist_q[WIDTH-2:0], din};
               if (fill_q != FILL_W'(WIDTH)) begin
                  fill_d = fill_q + FILL_W'(1);
               end else if (din != pred_s) begin
                  match_d = {MATCH_W{1'b0}};
               end else if (match_q != MATCH_W'(LOCK_CNT - 1)) begin
                  match_d = match_q + MATCH_W'(1);
               end else if (hist_d != {WIDTH{1'b0}}) begin
                  // An all-zero history is self-consistent but carries no pattern.
                  state_d = ST_LOCKED;
                  match_d = {MATCH_W{1'b0}};
                  win_d   = {WIN_W{1'b0}};
                  bad_d   = {BAD_W{1'b0}};
               end else begin
                  match_d = match_q;
               end
            end
            ST_LOCKED: begin
               hist_d    = {hist_q[WIDTH-2:0], pred_s};
               miss_s    = (din != pred_s);
               bad_inc_s = miss_s ? (bad_q + BAD_W'(1)) : bad_q;
               // The error on a wrap bit still belongs to the closing window.
               if (bad_inc_s == BAD_W'(UNLOCK_ERR)) begin
                  state_d = ST_SEARCH;
                  hist_d  = {WIDTH{1'b0}};
                  fill_d  = {FILL_W{1'b0}};
                  match_d = {MATCH_W{1'b0}};
                  win_d   = {WIN_W{1'b0}};
                  bad_d   = {BAD_W{1'b0}};
               end else if (win_q == WIN_W'(WINDOW - 1)) begin
                  win_d = {WIN_W{1'b0}};
                  bad_d = {BAD_W{1'b0}};
               end else begin
                  win_d = win_q + WIN_W'(1);
                  bad_d = bad_inc_s;
               end
            end
            default: begin
               state_d = ST_SEARCH;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      err_d = miss_s;

      // Clear first, then count, so a simultaneous error leaves a count of one.
      if (clr_cnt) begin
         cnt_base_s = {CNT_W{1'b0}};
      end else begin
         cnt_base_s = err_cnt_q;
      end
      if (miss_s && (cnt_base_s != {CNT_W{1'b1}})) begin
         err_cnt_d = cnt_base_s + CNT_W'(1);
      end else begin
         err_cnt_d = cnt_base_s;
      end

      locked_d = (state_d == ST_LOCKED);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= ST_SEARCH;
         hist_q    <= {WIDTH{1'b0}};
         fill_q    <= {FILL_W{1'b0}};
         match_q   <= {MATCH_W{1'b0}};
         win_q     <= {WIN_W{1'b0}};
         bad_q     <= {BAD_W{1'b0}};
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= {CNT_W{1'b0}};
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         match_q   <= match_d;
         win_q     <= win_d;
         bad_q     <= bad_d;
         locked_q  <= locked_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign locked  = locked_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: table of directed stream scenarios with expected
// event positions, hand-written clear/reset sequences, and a randomized run.
// Every cycle is compared against a queue-based reference model.
module tb_prbs_checker;

   localparam int NSTREAM = 12000;
   localparam int DELAYS[4] = '{16, 14, 13, 11};

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        din = 1'b0;
   logic        din_vld = 1'b0;
   logic        clr_cnt = 1'b0;
   logic        locked;
   logic        err;
   logic [15:0] err_cnt;

   prbs_checker dut (
      .clk(clk), .rst_b(rst_b), .din(din), .din_vld(din_vld),
      .clr_cnt(clr_cnt), .locked(locked), .err(err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference stream
   bit stream[NSTREAM];
   int sidx;
   int vbits;
   bit use_zeros;

   // observed events (valid-bit numbers, 0 = never)
   int lock_bit, unlock_bit, relock_bit, first_err, pulses;
   bit prev_locked;

   // reference model state
   bit m_h[$];
   bit m_locked, m_err;
   int m_match, m_win, m_bad, m_cnt;

   typedef struct {
      int n_bits;
      int b1_s; int b1_n;
      int b2_s; int b2_n;
      bit zeros;
      bit toggle;
      int exp_lock; int exp_unlock; int exp_relock;
      int exp_first_err; int exp_cnt; int exp_pulses;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit m_pred();
      bit p;
      p = 1'b0;
      for (int i = 0; i < 4; i++) p ^= m_h[m_h.size() - DELAYS[i]];
      return p;
   endfunction

   function automatic void model_reset();
      m_h.delete();
      m_locked = 1'b0; m_err = 1'b0;
      m_match = 0; m_win = 0; m_bad = 0; m_cnt = 0;
   endfunction

   function automatic void model_step(bit d, bit v, bit c);
      bit p, hit, all0;
      hit = 1'b0;
      if (v) begin
         if (!m_locked) begin
            if (m_h.size() < 16) begin
               m_h.push_back(d);
            end else begin
               p = m_pred();
               m_h.push_back(d);
               void'(m_h.pop_front());
               all0 = 1'b1;
               foreach (m_h[i]) if (m_h[i]) all0 = 1'b0;
               if (d != p) m_match = 0;
               else if (m_match + 1 < 32) m_match++;
               else if (!all0) begin
                  m_locked = 1'b1; m_match = 0; m_win = 0; m_bad = 0;
               end
            end
         end else begin
            p = m_pred();
            m_h.push_back(p);
            void'(m_h.pop_front());
            if (d != p) begin hit = 1'b1; m_bad++; end
            if (m_bad == 8) begin
               m_locked = 1'b0; m_h.delete(); m_match = 0; m_win = 0; m_bad = 0;
            end else begin
               m_win++;
               if (m_win == 64) begin m_win = 0; m_bad = 0; end
            end
         end
      end
      if (c) m_cnt = 0;
      if (hit && m_cnt < 65535) m_cnt++;
      m_err = hit;
   endfunction

   task automatic do_reset();
      rst_b = 1'b0; din = 1'b0; din_vld = 1'b0; clr_cnt = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_locked", int'(locked), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      model_reset();
      sidx = 0; vbits = 0; use_zeros = 1'b0;
      lock_bit = 0; unlock_bit = 0; relock_bit = 0; first_err = 0; pulses = 0;
      prev_locked = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
   endtask

   // one clock: drive, step model, compare
   task automatic send(input bit flip, input bit vld, input bit clr);
      bit d;
      if (vld) begin
         d = use_zeros ? 1'b0 : stream[sidx];
         d ^= flip;
         sidx++; vbits++;
      end else begin
         d = 1'($urandom_range(0, 1));
      end
      din = d; din_vld = vld; clr_cnt = clr;
      @(posedge clk);
      model_step(d, vld, clr);
      #1;
      chk("cyc_locked", int'(locked), int'(m_locked));
      chk("cyc_err", int'(err), int'(m_err));
      chk("cyc_err_cnt", int'(err_cnt), m_cnt);
      if (locked && !prev_locked) begin
         if (lock_bit == 0) lock_bit = vbits;
         else if (relock_bit == 0) relock_bit = vbits;
      end
      if (!locked && prev_locked && unlock_bit == 0) unlock_bit = vbits;
      if (err) begin
         pulses++;
         if (first_err == 0) first_err = vbits;
      end
      prev_locked = locked;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      bit f;
      do_reset();
      use_zeros = v.zeros;
      for (int b = 1; b <= v.n_bits; b++) begin
         f = (b >= v.b1_s && b < v.b1_s + v.b1_n) || (b >= v.b2_s && b < v.b2_s + v.b2_n);
         if (v.toggle) send(1'b0, 1'b0, 1'b0);
         send(f, 1'b1, 1'b0);
      end
      chk($sformatf("v%0d_lock_bit", idx), lock_bit, v.exp_lock);
      chk($sformatf("v%0d_unlock_bit", idx), unlock_bit, v.exp_unlock);
      chk($sformatf("v%0d_relock_bit", idx), relock_bit, v.exp_relock);
      chk($sformatf("v%0d_first_err", idx), first_err, v.exp_first_err);
      chk($sformatf("v%0d_err_cnt", idx), int'(err_cnt), v.exp_cnt);
      chk($sformatf("v%0d_pulses", idx), pulses, v.exp_pulses);
   endtask

   initial begin
      bit [15:0] seed;
      bit f;
      int rate;

      // clean stream: seed bits, then b[n] = b[n-16]^b[n-14]^b[n-13]^b[n-11]
      seed = 16'hACE1;
      for (int n = 0; n < NSTREAM; n++) begin
         if (n < 16) stream[n] = seed[n];
         else stream[n] = stream[n-16] ^ stream[n-14] ^ stream[n-13] ^ stream[n-11];
      end

      //          n      b1s b1n b2s b2n zero tog lock unl relk 1stErr cnt pulses
      vecs[0] = '{10048, 0,  0,  0,  0,  1'b0,1'b0, 48, 0,  0,   0,     0,  0};
      vecs[1] = '{400,   200,1,  0,  0,  1'b0,1'b0, 48, 0,  0,   200,   1,  1};
      vecs[2] = '{400,   120,8,  0,  0,  1'b0,1'b0, 48, 127,175, 120,   8,  8};
      vecs[3] = '{400,   100,7,  113,7,  1'b0,1'b0, 48, 0,  0,   100,   14, 14};
      vecs[4] = '{500,   0,  0,  0,  0,  1'b1,1'b0, 0,  0,  0,   0,     0,  0};
      vecs[5] = '{200,   0,  0,  0,  0,  1'b0,1'b1, 48, 0,  0,   0,     0,  0};

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // clear coinciding with a counted error, then async reset mid-lock
      do_reset();
      for (int b = 1; b <= 90; b++) begin
         f = (b == 70) || (b == 72) || (b == 74) || (b == 76) || (b == 78);
         send(f, 1'b1, 1'b0);
      end
      chk("cnt_before_clr", int'(err_cnt), 5);
      send(1'b1, 1'b1, 1'b1);
      chk("clr_with_err", int'(err_cnt), 1);
      chk("clr_keeps_lock", int'(locked), 1);
      send(1'b0, 1'b1, 1'b1);
      chk("clr_only", int'(err_cnt), 0);
      send(1'b1, 1'b1, 1'b0);
      chk("pre_rst_cnt", int'(err_cnt), 1);
      chk("pre_rst_locked", int'(locked), 1);
      #3;
      rst_b = 1'b0;
      #1;
      chk("async_rst_locked", int'(locked), 0);
      chk("async_rst_err_cnt", int'(err_cnt), 0);
      chk("async_rst_err", int'(err), 0);

      // randomized: sparse-valid traffic with alternating quiet/noisy phases
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         rate = ((c / 500) % 2 == 1) ? 12 : 1;
         send(1'($urandom_range(0, 99) < rate),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 99) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
